// File: rtl/func_issuer_if.sv
// Bundle of the instruction-buffer write port, issue handshake and status
// flags shared between the func_issuer and whatever feeds/consumes it.
interface func_issuer_if #(
    parameter int DEPTH = 8
);
    logic                     wr_en;
    logic [24:0]              wr_func;
    logic                     start;
    logic                     done;
    logic                     clr_err;
    logic [24:0]              func;
    logic                     new_func;
    logic                     busy;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic [7:0]               issued_cnt;
    logic                     error;
    logic                     overflow;

    modport master (
        output wr_en, wr_func, start, done, clr_err,
        input  func, new_func, busy, full, empty, level, issued_cnt, error, overflow
    );

    modport slave (
        input  wr_en, wr_func, start, done, clr_err,
        output func, new_func, busy, full, empty, level, issued_cnt, error, overflow
    );
endinterface

// File: rtl/func_issuer.sv
// Buffers instruction words in a FIFO and issues them one at a time to a
// control unit, waiting for a done pulse (with timeout) before the next one.
module func_issuer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    func_issuer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_t;

    state_t          state;
    logic [24:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   cnt;
    logic [TW-1:0]   timer;
    logic [24:0]     func_r;
    logic            new_func_r;
    logic            busy_r;
    logic [7:0]      issued_r;
    logic            error_r;
    logic            overflow_r;

    logic            full_w;
    logic            empty_w;
    logic            push;
    logic            pop;

    assign full_w  = (cnt == LW'(DEPTH));
    assign empty_w = (cnt == '0);
    // Fullness is judged before any same-cycle pop, so a full buffer drops the write.
    assign push    = bus.wr_en && !full_w;
    assign pop     = (state == WAIT) && bus.done;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_func;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            timer      <= '0;
            func_r     <= '0;
            new_func_r <= 1'b0;
            busy_r     <= 1'b0;
            issued_r   <= '0;
            error_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            new_func_r <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                issued_r <= issued_r + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            if (bus.clr_err) begin
                overflow_r <= 1'b0;
            end
            if (bus.wr_en && full_w) begin
                overflow_r <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (bus.start && !empty_w) begin
                        state  <= ISSUE;
                        busy_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    func_r     <= mem[rd_ptr];
                    new_func_r <= 1'b1;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a timeout landing in the same cycle
                    if (bus.done) begin
                        if (bus.start && ((cnt > LW'(1)) || push)) begin
                            state <= ISSUE;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state   <= ERROR;
                        error_r <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ERROR: begin
                    if (bus.clr_err) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        error_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.func       = func_r;
    assign bus.new_func   = new_func_r;
    assign bus.busy       = busy_r;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.level      = cnt;
    assign bus.issued_cnt = issued_r;
    assign bus.error      = error_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_func_issuer.sv
// Directed bench for func_issuer: single issue, FIFO order/spacing, overflow,
// timeout/error recovery, done-vs-timeout race, mid-WAIT reset, push on full.
module tb_func_issuer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   strobes = 0;
    int   consec = 0;
    logic prev_nf = 1'b0;

    always #5 clk = ~clk;

    func_issuer_if #(.DEPTH(8)) bus ();

    func_issuer #(.DEPTH(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Strobe monitor samples shortly after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (bus.new_func) strobes++;
        if (bus.new_func && prev_nf) consec++;
        prev_nf = bus.new_func;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.wr_en   = 1'b0;
        bus.wr_func = '0;
        bus.start   = 1'b0;
        bus.done    = 1'b0;
        bus.clr_err = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic [24:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_func = w;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int max, output int n);
        n = 0;
        while (!bus.new_func && n < max) begin
            tick();
            n++;
        end
        if (!bus.new_func) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [24:0] mkw(input int i);
        logic [2:0] op;
        op = 3'(i);
        return {op, 3'b101, ~op, 16'hA000 + 16'(i)};
    endfunction

    localparam logic [24:0] W1 = 25'b000_001_000_0000_0000_0000_1111;
    localparam logic [24:0] XW = 25'h1FF_FFFF;
    localparam logic [24:0] YW = 25'h0ABCDEF;

    int n;
    int base;
    logic [24:0] tw [3];

    initial begin
        tw[0] = 25'h1111111;
        tw[1] = 25'h0222222;
        tw[2] = 25'h1333333;

        // Reset state
        do_reset();
        chk("rst_func", bus.func, 0);
        chk("rst_new_func", bus.new_func, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_issued", bus.issued_cnt, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_overflow", bus.overflow, 0);

        // Single instruction, done 3 cycles after strobe
        base = strobes;
        push(W1);
        bus.start = 1'b1;
        wait_strobe("t1", 10, n);
        chk("t1_func", bus.func, W1);
        chk("t1_busy_wait", bus.busy, 1);
        tick(); tick(); tick();
        chk("t1_func_held", bus.func, W1);
        chk("t1_nf_low", bus.new_func, 0);
        pulse_done();
        chk("t1_issued", bus.issued_cnt, 1);
        chk("t1_empty", bus.empty, 1);
        chk("t1_busy", bus.busy, 0);
        tick(); tick();
        chk("t1_strobes", strobes - base, 1);
        chk("t1_func_idle", bus.func, W1);

        // Three words, done 2 cycles after each strobe, strobes 4 apart
        do_reset();
        for (int i = 0; i < 3; i++) push(tw[i]);
        chk("t2_level", bus.level, 3);
        bus.start = 1'b1;
        wait_strobe("t2_s0", 10, n);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_func%0d", i), bus.func, tw[i]);
            tick(); tick();
            pulse_done();
            if (i < 2) begin
                wait_strobe($sformatf("t2_s%0d", i + 1), 10, n);
                chk($sformatf("t2_gap%0d", i), 3 + n, 4);
            end
        end
        chk("t2_issued", bus.issued_cnt, 3);
        chk("t2_busy", bus.busy, 0);

        // Nine pushes into depth-8 buffer with start low
        do_reset();
        base = strobes;
        for (int i = 0; i < 9; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_func = mkw(i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("t3_full", bus.full, 1);
        chk("t3_level", bus.level, 8);
        chk("t3_overflow", bus.overflow, 1);
        pulse_done();
        chk("t3_done_idle_issued", bus.issued_cnt, 0);
        chk("t3_done_idle_level", bus.level, 8);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("t3_ovf_clr", bus.overflow, 0);
        bus.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_strobe($sformatf("t3_s%0d", i), 10, n);
            chk($sformatf("t3_func%0d", i), bus.func, mkw(i));
            pulse_done();
        end
        repeat (4) tick();
        chk("t3_strobes", strobes - base, 8);
        chk("t3_issued", bus.issued_cnt, 8);
        chk("t3_empty", bus.empty, 1);

        // Timeout to ERROR, clear and reissue
        do_reset();
        push(W1);
        bus.start = 1'b1;
        wait_strobe("t4_s0", 10, n);
        n = 0;
        while (!bus.error && n < 40) begin
            tick();
            n++;
        end
        chk("t4_err_latency", n, 15);
        chk("t4_error", bus.error, 1);
        chk("t4_busy", bus.busy, 1);
        chk("t4_level", bus.level, 1);
        base = strobes;
        repeat (3) tick();
        chk("t4_no_issue_err", strobes - base, 0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("t4_err_clr", bus.error, 0);
        wait_strobe("t4_s1", 10, n);
        chk("t4_reissue", bus.func, W1);
        pulse_done();
        chk("t4_issued", bus.issued_cnt, 1);
        chk("t4_empty", bus.empty, 1);

        // done in the very cycle the timer reaches TIMEOUT
        push(YW);
        wait_strobe("t4b_s", 10, n);
        repeat (14) tick();
        pulse_done();
        chk("t4b_error", bus.error, 0);
        chk("t4b_issued", bus.issued_cnt, 2);
        chk("t4b_busy", bus.busy, 0);

        // Asynchronous reset mid-WAIT with four entries
        do_reset();
        for (int i = 0; i < 4; i++) push(mkw(i + 3));
        bus.start = 1'b1;
        wait_strobe("t5_s", 10, n);
        tick(); tick();
        chk("t5_busy_pre", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_func", bus.func, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_empty", bus.empty, 1);
        chk("t5_level", bus.level, 0);
        chk("t5_issued", bus.issued_cnt, 0);
        chk("t5_new_func", bus.new_func, 0);
        tick();
        reset = 1'b0;
        base = strobes;
        repeat (20) tick();
        chk("t5_no_strobe", strobes - base, 0);

        // Full buffer, push during done; then push+pop at equal level
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_func = mkw(i);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b1;
        wait_strobe("t6_s0", 10, n);
        chk("t6_func0", bus.func, mkw(0));
        bus.wr_en = 1'b1;
        bus.wr_func = XW;
        pulse_done();
        bus.wr_en = 1'b0;
        chk("t6_overflow", bus.overflow, 1);
        chk("t6_level7", bus.level, 7);
        chk("t6_full", bus.full, 0);
        wait_strobe("t6_s1", 10, n);
        chk("t6_func1", bus.func, mkw(1));
        bus.wr_en = 1'b1;
        bus.wr_func = YW;
        pulse_done();
        bus.wr_en = 1'b0;
        chk("t6_level_pushpop", bus.level, 7);
        for (int i = 2; i < 8; i++) begin
            wait_strobe($sformatf("t6_s%0d", i), 10, n);
            chk($sformatf("t6_func%0d", i), bus.func, mkw(i));
            pulse_done();
        end
        wait_strobe("t6_sy", 10, n);
        chk("t6_funcy", bus.func, YW);
        pulse_done();
        chk("t6_issued", bus.issued_cnt, 9);
        chk("t6_empty", bus.empty, 1);

        chk("nf_consecutive", consec, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
